// File: rtl/kpd_pkg.sv
// Shared types and constants for the keypad entry controller.
package kpd_pkg;

  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [3:0] KEY_A = 4'hA;  // commit
  localparam logic [3:0] KEY_B = 4'hB;  // backspace
  localparam logic [3:0] KEY_C = 4'hC;  // reserved
  localparam logic [3:0] KEY_D = 4'hD;  // clear

  typedef logic [BCD_W-1:0] bcd_num_t;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} deb_state_e;
  typedef enum logic       {EDIT, SEND} entry_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'h9;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Committed-number handshake between the keypad controller and its consumer.
interface keypad_entry_ctrl_if;
  import kpd_pkg::*;

  bcd_num_t num_bcd;
  logic     num_valid;
  logic     num_ready;

  modport master (output num_bcd, output num_valid, input  num_ready);
  modport slave  (input  num_bcd, input  num_valid, output num_ready);
endinterface

// File: rtl/kpd_debounce.sv
// Press/release debouncer: one press_evt pulse per debounced key press, no auto-repeat.
module kpd_debounce
  import kpd_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       press_evt,
  output logic [3:0] press_code
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES);

  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic          evt_q, evt_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      evt_q   <= evt_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    evt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          cnt_d   = CNT_ONE;
          cand_d  = key_code;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (key_valid && key_code == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = CNT_MAX;
            evt_d   = 1'b1;
            state_d = HELD;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      HELD: begin
        if (!key_valid) begin
          cnt_d   = CNT_ONE;
          state_d = REL_WAIT;
        end
      end
      REL_WAIT: begin
        if (key_valid) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign press_evt  = evt_q;
  assign press_code = cand_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad number entry: debounced keys edit a 3-digit BCD buffer, key A commits it over a valid/ready handshake.
module keypad_entry_ctrl
  import kpd_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 key_code,
  input  logic                       key_valid,
  keypad_entry_ctrl_if.master        num,
  output bcd_num_t                   disp_bcd,
  output logic [1:0]                 digit_cnt,
  output logic                       overflow
);

  localparam logic [1:0] DIGITS_MAX = 2'(BCD_DIGITS);

  logic       press_evt;
  logic [3:0] press_code;

  kpd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .press_evt  (press_evt),
    .press_code (press_code)
  );

  entry_state_e ent_q, ent_d;
  bcd_num_t     edit_q, edit_d;
  bcd_num_t     num_q, num_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q  <= EDIT;
      edit_q <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ent_q  <= ent_d;
      edit_q <= edit_d;
      num_q  <= num_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    ent_d  = ent_q;
    edit_d = edit_q;
    num_d  = num_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;

    if (ent_q == SEND && num.num_ready) ent_d = EDIT;

    // Clear works in both states; everything else is dropped while a number awaits collection.
    if (press_evt) begin
      if (press_code == KEY_D) begin
        edit_d = '0;
        cnt_d  = '0;
        ovf_d  = 1'b0;
      end else if (ent_q == EDIT) begin
        if (is_digit(press_code)) begin
          if (cnt_q == DIGITS_MAX) begin
            ovf_d = 1'b1;
          end else begin
            edit_d = {edit_q[BCD_W-5:0], press_code};
            cnt_d  = cnt_q + 2'd1;
          end
        end else if (press_code == KEY_A) begin
          if (cnt_q != 2'd0) begin
            num_d  = edit_q;
            edit_d = '0;
            cnt_d  = '0;
            ent_d  = SEND;
          end
        end else if (press_code == KEY_B) begin
          ovf_d = 1'b0;
          if (cnt_q != 2'd0) begin
            edit_d = {4'h0, edit_q[BCD_W-1:4]};
            cnt_d  = cnt_q - 2'd1;
          end
        end
      end
    end
  end

  assign num.num_bcd   = num_q;
  assign num.num_valid = (ent_q == SEND);
  assign disp_bcd      = edit_q;
  assign digit_cnt     = cnt_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench: directed scenarios plus random key traffic against a queue-based behavioural model.
module tb_keypad_entry_ctrl;
  import kpd_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  bcd_num_t   disp_bcd;
  logic [1:0] digit_cnt;
  logic       overflow;

  keypad_entry_ctrl_if num_if ();

  keypad_entry_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_valid (key_valid),
    .num       (num_if),
    .disp_bcd  (disp_bcd),
    .digit_cnt (digit_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_digits[$];   // edit buffer, oldest digit first
  bcd_num_t   m_num;
  bit         m_valid;
  bit         m_ovf;
  bit         m_evt;
  logic [3:0] m_code;
  bit         latched;       // a press was accepted and its release is not yet debounced
  int         run;           // consecutive valid samples of run_code
  logic [3:0] run_code;
  int         low;           // consecutive released samples while latched
  bit         new_evt;
  bit         was_send;

  function automatic bcd_num_t pack(input int q[$]);
    bcd_num_t v = '0;
    foreach (q[i]) v = (v << 4) | bcd_num_t'(q[i]);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_digits.delete();
      m_num = '0; m_valid = 0; m_ovf = 0; m_evt = 0; m_code = '0;
      latched = 0; run = 0; run_code = '0; low = 0;
    end else begin
      // entry side: the event seen on the previous edge takes effect now
      was_send = m_valid;
      if (m_valid && num_if.num_ready) m_valid = 0;
      if (m_evt) begin
        if (m_code == 4'hD) begin
          m_digits.delete();
          m_ovf = 0;
        end else if (!was_send) begin
          if (m_code <= 4'h9) begin
            if (m_digits.size() < 3) m_digits.push_back(int'(m_code));
            else m_ovf = 1;
          end else if (m_code == 4'hA) begin
            if (m_digits.size() > 0) begin
              m_num = pack(m_digits);
              m_digits.delete();
              m_valid = 1;
            end
          end else if (m_code == 4'hB) begin
            m_ovf = 0;
            if (m_digits.size() > 0) void'(m_digits.pop_back());
          end
        end
      end
      // debounce side: a sample that breaks a run is not itself the start of a new run
      new_evt = 0;
      if (!latched) begin
        if (key_valid && run > 0 && key_code == run_code) run++;
        else if (key_valid && run == 0) begin run = 1; run_code = key_code; end
        else run = 0;
        if (run == DEB) begin
          new_evt = 1; m_code = run_code; latched = 1; run = 0; low = 0;
        end
      end else begin
        if (!key_valid) low++; else low = 0;
        if (low == DEB) begin latched = 0; low = 0; end
      end
      m_evt = new_evt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("disp_bcd", 32'(disp_bcd), 32'(pack(m_digits)));
      check("digit_cnt", 32'(digit_cnt), 32'(m_digits.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("num_valid", 32'(num_if.num_valid), 32'(m_valid));
      check("num_bcd", 32'(num_if.num_bcd), 32'(m_num));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) num_if.num_ready = ($urandom_range(0, 2) == 0);
  endtask

  task automatic press(input logic [3:0] c, input int hold, input int rel);
    key_code  = c;
    key_valid = 1'b1;
    repeat (hold) step();
    key_valid = 1'b0;
    repeat (rel) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_disp"}, 32'(disp_bcd), 32'h0);
    check({tag, "_cnt"}, 32'(digit_cnt), 32'h0);
    check({tag, "_ovf"}, 32'(overflow), 32'h0);
    check({tag, "_valid"}, 32'(num_if.num_valid), 32'h0);
    check({tag, "_num"}, 32'(num_if.num_bcd), 32'h0);
  endtask

  initial begin
    num_if.num_ready = 1'b0;
    rst = 1'b1;
    step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // short press is rejected
    press(4'h5, 3, 6);
    check("short_disp", 32'(disp_bcd), 32'h0);

    // three digits, then overflow
    press(4'h1, 6, 6); press(4'h2, 6, 6); press(4'h3, 6, 6);
    check("three_disp", 32'(disp_bcd), 32'h123);
    check("three_cnt", 32'(digit_cnt), 32'd3);
    press(4'h4, 6, 6);
    check("ovf_disp", 32'(disp_bcd), 32'h123);
    check("ovf_flag", 32'(overflow), 32'h1);
    press(KEY_D, 6, 6);
    check("clear_cnt", 32'(digit_cnt), 32'd0);
    check("clear_ovf", 32'(overflow), 32'h0);

    // commit with backspace, held by the consumer
    press(4'h7, 6, 6); press(4'h8, 6, 6); press(KEY_B, 6, 6); press(KEY_A, 6, 6);
    check("commit_num", 32'(num_if.num_bcd), 32'h007);
    check("commit_valid", 32'(num_if.num_valid), 32'h1);
    repeat (10) step();
    check("hold_valid", 32'(num_if.num_valid), 32'h1);
    num_if.num_ready = 1'b1;
    step();
    num_if.num_ready = 1'b0;
    check("hs_valid", 32'(num_if.num_valid), 32'h0);

    // keys while waiting for the consumer
    press(4'h5, 6, 6); press(KEY_A, 6, 6);
    press(4'h9, 6, 6);
    check("send_drop_cnt", 32'(digit_cnt), 32'd0);
    press(KEY_D, 6, 6);
    check("send_d_cnt", 32'(digit_cnt), 32'd0);
    check("send_d_valid", 32'(num_if.num_valid), 32'h1);
    check("send_d_num", 32'(num_if.num_bcd), 32'h005);
    num_if.num_ready = 1'b1;
    step();
    num_if.num_ready = 1'b0;

    // long hold with a release glitch
    key_code = 4'h2; key_valid = 1'b1;
    repeat (24) step();
    key_valid = 1'b0;
    repeat (2) step();
    key_valid = 1'b1;
    repeat (24) step();
    key_valid = 1'b0;
    repeat (6) step();
    check("glitch_cnt", 32'(digit_cnt), 32'd1);
    check("glitch_disp", 32'(disp_bcd), 32'h002);

    // reset mid-debounce and in SEND
    key_code = 4'h3; key_valid = 1'b1;
    step(); step();
    rst = 1'b1; key_valid = 1'b0;
    step();
    rst = 1'b0;
    check_all_zero("rst_pw");
    press(4'h1, 6, 6); press(KEY_A, 6, 6);
    check("pre_rst_valid", 32'(num_if.num_valid), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_send");
    press(4'h6, 6, 6);
    check("post_rst_disp", 32'(disp_bcd), 32'h006);

    // random traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int hold;
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      key_code  = 4'($urandom_range(0, 15));
      key_valid = 1'b1;
      hold = $urandom_range(1, 8);
      for (int j = 0; j < hold; j++) begin
        key_valid = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 11) == 0) key_code = 4'($urandom_range(0, 15));
        step();
      end
      key_valid = 1'b0;
      repeat ($urandom_range(1, 7)) step();
    end
    rand_ready = 1'b0;
    num_if.num_ready = 1'b0;
    repeat (10) step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 50000: number of consecutive stable cycles required to accept a press or a release (minimum 2).
REQ-002 clk  input  1  single system clock; all logic is rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 key_code  input  4  scanner key code: 0x0-0x9 digits; 0xA/0xB/0xC/0xD keys A/B/C/D; any other value, including X, is invalid.
REQ-005 key_valid  input  1  scanner level; high while a key is decoded.
REQ-006 num_bcd  output  12  committed 3-digit BCD number; [11:8] hundreds, [3:0] units.
REQ-007 num_valid  output  1  high while num_bcd holds an uncollected number.
REQ-008 num_ready  input  1  consumer accepts num_bcd on a cycle where num_valid & num_ready.
REQ-009 disp_bcd  output  12  live edit buffer, for the display.
REQ-010 digit_cnt  output  2  digits in the edit buffer, 0-3.
REQ-011 overflow  output  1  sticky flag; set when a 4th digit is attempted.

Function
REQ-012 Debounce FSM states: IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-013 IDLE: key_valid=1 loads cnt=1 and samples the code into cand, then goes to PRESS_WAIT.
REQ-014 PRESS_WAIT: each cycle with key_valid=1 and key_code==cand increments cnt.
REQ-015 PRESS_WAIT: key_valid=0 or a code change returns to IDLE with cnt cleared.
REQ-016 PRESS_WAIT: when cnt reaches DEB_CYCLES, emit a one-cycle internal press event carrying cand and go to HELD.
REQ-017 HELD: key_valid=0 loads cnt=1 and goes to REL_WAIT; no further events occur while the key is held (no auto-repeat).
REQ-018 REL_WAIT: key_valid=1 returns to HELD; DEB_CYCLES consecutive low cycles return to IDLE.
REQ-019 The debounce counter SHALL be $clog2(DEB_CYCLES+1) bits wide and saturate, never wrap.
REQ-020 Entry FSM states: EDIT and SEND.
REQ-021 EDIT, digit d with digit_cnt<3: buffer={buffer[7:0],d} and digit_cnt+1, both visible the cycle after the press event.
REQ-022 EDIT, digit with digit_cnt==3: buffer unchanged; overflow set.
REQ-023 EDIT, key A with digit_cnt>0: num_bcd=buffer, num_valid=1, buffer and digit_cnt cleared, go to SEND.
REQ-024 EDIT, key A with digit_cnt==0: ignored.
REQ-025 Key B (backspace): buffer={4'h0,buffer[11:4]} and digit_cnt-1; no effect when digit_cnt==0; clears overflow.
REQ-026 Key C: ignored (reserved).
REQ-027 Key D (clear): buffer=0, digit_cnt=0, overflow=0.
REQ-028 Invalid codes SHALL generate no event.
REQ-029 SEND: num_bcd and num_valid are held stable until num_valid & num_ready, then num_valid=0 on the next edge and the FSM returns to EDIT.
REQ-030 SEND: key D is still honoured on the edit buffer; all other press events are dropped; the debounce FSM keeps running.
REQ-031 A press event and a handshake in the same cycle: the handshake completes; the event is processed only if it is D.
REQ-032 num_ready is ignored while num_valid=0.

Reset
REQ-033 rst=1 at any clock edge, including mid-debounce or in SEND, forces: both FSMs to IDLE/EDIT; cnt=0; cand=0; num_bcd=0; num_valid=0; disp_bcd=0; digit_cnt=0; overflow=0.
REQ-034 The first press after reset requires a full DEB_CYCLES stable window.

Structure
REQ-035 A shared package kpd_pkg SHALL hold: key-code constants KEY_A..KEY_D; the debounce-state and entry-state enums; and BCD_DIGITS=3.
REQ-036 The debouncer SHALL be a sub-module kpd_debounce (DEB_CYCLES; outputs press_evt, press_code), instantiated once.

Verification (DEB_CYCLES=4)
REQ-037 Hold code 5 for 3 cycles, then release -> no event; disp_bcd=0.
REQ-038 Press 1, 2, 3 (each held 6 cycles, released 6) -> disp_bcd=0x123, digit_cnt=3; a further press of 4 -> disp_bcd unchanged, overflow=1.
REQ-039 Press 7, 8, B, A with num_ready=0 -> num_bcd=0x007, num_valid stays 1 for 10 cycles; then num_ready=1 for one cycle -> num_valid=0 on the next cycle.
REQ-040 Press 9 while in SEND -> digit dropped; press D while in SEND -> digit_cnt=0, num_valid remains 1.
REQ-041 Hold key 2 for 50 cycles with a 2-cycle key_valid glitch low mid-hold -> exactly one digit entered.
REQ-042 Assert rst in PRESS_WAIT and again in SEND -> all outputs 0 next cycle; a subsequent press of 6 -> disp_bcd=0x006.
